// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// opcodes, datapath select encodings and the packed control vector.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST       = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_EXEC      = 4'd6,
        ST_R_WB      = 4'd7,
        ST_MEM_WRITE = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_ADDI_EX   = 4'd11,
        ST_ADDI_WB   = 4'd12,
        ST_ILLEGAL   = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // First state after DECODE for each supported opcode; unknown opcodes trap.
    function automatic state_e decode_op(input logic [5:0] op);
        case (op)
            OP_RTYPE:     return ST_EXEC;
            OP_LW, OP_SW: return ST_MEM_ADDR;
            OP_BEQ:       return ST_BRANCH;
            OP_J:         return ST_JUMP;
            OP_ADDI:      return ST_ADDI_EX;
            default:      return ST_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Combinational lookup from FSM state to the datapath control vector.
// fetch_ack_i gates the IR/PC writes in FETCH so a stalled fetch writes nothing.
module mc_ctrl_outputs
    import mc_ctrl_pkg::*;
(
    input  logic [3:0]        state_i,
    input  logic              fetch_ack_i,
    output logic [CTRL_W-1:0] ctrl_o
);

    ctrl_t c;

    always_comb begin
        c = '0;
        case (state_e'(state_i))
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = fetch_ack_i;
                c.pc_write  = fetch_ack_i;
                c.alu_src_b = SRCB_FOUR;
            end
            ST_DECODE: c.alu_src_b = SRCB_IMM_SH2;
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            ST_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            ST_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            ST_ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            ST_ADDI_WB: c.reg_write = 1'b1;
            default: ;
        endcase
    end

    assign ctrl_o = c;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control: Moore sequencer, retired-instruction counter and sticky flags.
// Define MC_CTRL_WAIT_EN to stall memory states on mem_ready with a MAX_WAIT timeout.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             ir_write,
    output logic             alu_src_a,
    output logic             reg_write,
    output logic             reg_dst,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       state_out,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal_op,
    output logic             bus_timeout
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              illegal_q, illegal_d;
    logic              fetch_ack, mem_stall, wait_expired, retire;
    logic [CTRL_W-1:0] ctrl_vec;
    ctrl_t             ctrl;

`ifdef MC_CTRL_WAIT_EN
    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q;

    assign fetch_ack    = mem_ready;
    assign mem_stall    = !mem_ready && (state_q == ST_FETCH || state_q == ST_MEM_READ ||
                                         state_q == ST_MEM_WRITE);
    assign wait_expired = mem_stall && (wait_q == WAIT_W'(MAX_WAIT));
    // Counter is zero on entry to any state and after a timeout restarts FETCH.
    assign wait_d       = (mem_stall && !wait_expired) ? wait_q + WAIT_W'(1) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_q | wait_expired;
        end
    end

    assign bus_timeout = timeout_q;
`else
    localparam int unused_max_wait = MAX_WAIT;
    logic unused_mem_ready;

    assign unused_mem_ready = mem_ready;
    assign fetch_ack        = 1'b1;
    assign mem_stall        = 1'b0;
    assign wait_expired     = 1'b0;
    assign bus_timeout      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_RST:      state_d = ST_FETCH;
            ST_FETCH:    if (!mem_stall) state_d = ST_DECODE;
            ST_DECODE:   state_d = decode_op(opcode);
            // IR holds the opcode, so bit 3 still separates sw from lw here.
            ST_MEM_ADDR: state_d = opcode[3] ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ: begin
                if (wait_expired)    state_d = ST_FETCH;
                else if (!mem_stall) state_d = ST_MEM_WB;
            end
            ST_MEM_WRITE: begin
                if (wait_expired) begin
                    state_d = ST_FETCH;
                end else if (!mem_stall) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_EXEC:     state_d = ST_R_WB;
            ST_ADDI_EX:  state_d = ST_ADDI_WB;
            ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            default:     state_d = ST_FETCH;
        endcase
    end

    assign count_d   = retire ? count_q + CNT_W'(1) : count_q;
    assign illegal_d = illegal_q | (state_d == ST_ILLEGAL);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RST;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    mc_ctrl_outputs u_outputs (
        .state_i     (state_q),
        .fetch_ack_i (fetch_ack),
        .ctrl_o      (ctrl_vec)
    );

    assign ctrl          = ctrl_vec;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign ir_write      = ctrl.ir_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;
    assign alu_src_b     = ctrl.alu_src_b;

    assign state_out   = state_q;
    assign instr_done  = retire;
    assign instr_count = count_q;
    assign illegal_op  = illegal_q;

endmodule
